// File: rtl/circle_cmd_sequencer.sv
// Command queue and issue sequencer for the filled-circle engine.
// Buffers circle commands in a small FIFO and hands them to the engine one at a time.
module circle_cmd_sequencer #(
    parameter int DEPTH        = 4,
    parameter int WIDTH_BITS   = 10,
    parameter int HEIGHT_BITS  = 9,
    parameter int CHANNEL_BITS = 8
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [WIDTH_BITS-1:0]      cmd_xC,
    input  logic [HEIGHT_BITS-1:0]     cmd_yC,
    input  logic [WIDTH_BITS-1:0]      cmd_rad,
    input  logic [CHANNEL_BITS-1:0]    cmd_r,
    input  logic [CHANNEL_BITS-1:0]    cmd_g,
    input  logic [CHANNEL_BITS-1:0]    cmd_b,
    input  logic                       abort,
    output logic [WIDTH_BITS-1:0]      xC,
    output logic [HEIGHT_BITS-1:0]     yC,
    output logic [WIDTH_BITS-1:0]      rad,
    output logic [CHANNEL_BITS-1:0]    r_o,
    output logic [CHANNEL_BITS-1:0]    g_o,
    output logic [CHANNEL_BITS-1:0]    b_o,
    output logic                       start,
    input  logic                       eng_done,
    input  logic                       eng_busy,
    output logic                       cmd_done,
    output logic [$clog2(DEPTH+1)-1:0] pending,
    output logic                       idle
);
    // state | meaning
    // IDLE  | waiting for a queued command; pops and loads engine parameters
    // ISSUE | start strobe to the engine for one cycle
    // WAIT  | engine running, waiting for eng_done

    localparam int PTR_BITS   = $clog2(DEPTH);
    localparam int CNT_BITS   = $clog2(DEPTH + 1);
    localparam int ENTRY_BITS = 2 * WIDTH_BITS + HEIGHT_BITS + 3 * CHANNEL_BITS;
    localparam logic [CNT_BITS-1:0] FULL_COUNT = CNT_BITS'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [ENTRY_BITS-1:0] mem [DEPTH];
    logic [PTR_BITS-1:0]   wr_ptr, rd_ptr;
    logic [CNT_BITS-1:0]   count;
    logic                  full, empty, push, pop;
    logic [ENTRY_BITS-1:0] entry_in, head;
    logic                  unused_busy;

    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
    assign cmd_ready = !full && !abort;
    assign push      = cmd_valid && cmd_ready;
    assign entry_in  = {cmd_xC, cmd_yC, cmd_rad, cmd_r, cmd_g, cmd_b};
    assign head      = mem[rd_ptr];
    assign start     = (state == ISSUE);
    assign idle      = (state == IDLE) && empty;
    assign pending   = count;
    // Engine busy is informational only; sequencing relies on eng_done.
    assign unused_busy = eng_busy;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !abort) begin
                    pop       = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (eng_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state    <= IDLE;
            cmd_done <= 1'b0;
            xC       <= '0;
            yC       <= '0;
            rad      <= '0;
            r_o      <= '0;
            g_o      <= '0;
            b_o      <= '0;
        end else begin
            state    <= state_nxt;
            cmd_done <= (state == WAIT) && eng_done;
            if (pop) begin
                {xC, yC, rad, r_o, g_o, b_o} <= head;
            end
        end
    end

    // Abort flushes only the queue; the command already popped runs to completion.
    always_ff @(posedge clk) begin
        if (!n_rst || abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_BITS'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_BITS'(1);
            count <= count + CNT_BITS'(push) - CNT_BITS'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= entry_in;
    end

endmodule

// File: tb/tb_circle_cmd_sequencer.sv
// Directed self-checking bench for circle_cmd_sequencer (DEPTH=4).
module tb_circle_cmd_sequencer;
    localparam int WB = 10;
    localparam int HB = 9;
    localparam int CB = 8;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [WB-1:0] cmd_xC = '0;
    logic [HB-1:0] cmd_yC = '0;
    logic [WB-1:0] cmd_rad = '0;
    logic [CB-1:0] cmd_r = '0;
    logic [CB-1:0] cmd_g = '0;
    logic [CB-1:0] cmd_b = '0;
    logic          abort = 1'b0;
    logic [WB-1:0] xC;
    logic [HB-1:0] yC;
    logic [WB-1:0] rad;
    logic [CB-1:0] r_o, g_o, b_o;
    logic          start;
    logic          eng_done = 1'b0;
    logic          eng_busy = 1'b0;
    logic          cmd_done;
    logic [2:0]    pending;
    logic          idle;

    int n_cmp = 0;
    int n_bad = 0;

    circle_cmd_sequencer #(
        .DEPTH(4), .WIDTH_BITS(WB), .HEIGHT_BITS(HB), .CHANNEL_BITS(CB)
    ) dut (
        .clk(clk), .n_rst(n_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_xC(cmd_xC), .cmd_yC(cmd_yC), .cmd_rad(cmd_rad),
        .cmd_r(cmd_r), .cmd_g(cmd_g), .cmd_b(cmd_b),
        .abort(abort),
        .xC(xC), .yC(yC), .rad(rad), .r_o(r_o), .g_o(g_o), .b_o(b_o),
        .start(start), .eng_done(eng_done), .eng_busy(eng_busy),
        .cmd_done(cmd_done), .pending(pending), .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int x, input int y, input int rd, input int c);
        cmd_valid = 1'b1;
        cmd_xC    = WB'(x);
        cmd_yC    = HB'(y);
        cmd_rad   = WB'(rd);
        cmd_r     = CB'(c);
        cmd_g     = CB'(c);
        cmd_b     = CB'(c);
    endtask

    task automatic drop_cmd();
        cmd_valid = 1'b0;
    endtask

    // Engine finishes: eng_done sampled while in WAIT gives one cmd_done cycle.
    task automatic complete(input string tag);
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        check({tag, "_done"}, 32'(cmd_done), 32'd1);
        check({tag, "_gap"}, 32'(start), 32'd0);
    endtask

    // Wait (bounded) for the next start, check the loaded centre, move on into WAIT.
    task automatic wait_start(input string tag, input int exp_x);
        int k;
        k = 0;
        while (!start && k < 30) begin
            tick();
            k++;
        end
        check({tag, "_start"}, 32'(start), 32'd1);
        check({tag, "_x"}, 32'(xC), 32'(exp_x));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int extra;
        logic rdy_seen [7];

        // reset values
        n_rst = 1'b0;
        repeat (3) tick();
        check("rst_xC", 32'(xC), 32'd0);
        check("rst_yC", 32'(yC), 32'd0);
        check("rst_rad", 32'(rad), 32'd0);
        check("rst_rgb", 32'({r_o, g_o, b_o}), 32'd0);
        check("rst_start", 32'(start), 32'd0);
        check("rst_cmd_done", 32'(cmd_done), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        n_rst = 1'b1;
        tick();
        check("rdy_after_rst", 32'(cmd_ready), 32'd1);

        // single command: push edge, load edge with start, then WAIT
        set_cmd(320, 240, 200, 255);
        tick();
        drop_cmd();
        check("s_pend", 32'(pending), 32'd1);
        check("s_start_early", 32'(start), 32'd0);
        tick();
        check("s_start", 32'(start), 32'd1);
        check("s_xC", 32'(xC), 32'd320);
        check("s_yC", 32'(yC), 32'd240);
        check("s_rad", 32'(rad), 32'd200);
        check("s_r", 32'(r_o), 32'd255);
        check("s_g", 32'(g_o), 32'd255);
        check("s_b", 32'(b_o), 32'd255);
        check("s_pend_pop", 32'(pending), 32'd0);
        tick();
        check("s_start_once", 32'(start), 32'd0);
        extra = 0;
        repeat (48) begin
            tick();
            if (start || cmd_done || xC != 10'd320) extra++;
        end
        check("s_wait_quiet", 32'(extra), 32'd0);
        complete("s");
        check("s_idle", 32'(idle), 32'd1);
        tick();
        check("s_pulse_len", 32'(cmd_done), 32'd0);
        check("s_hold_x", 32'(xC), 32'd320);

        // eng_done ignored in IDLE and in ISSUE
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        check("idle_done_ign", 32'(cmd_done), 32'd0);
        check("idle_stays", 32'(idle), 32'd1);
        set_cmd(5, 6, 7, 8);
        tick();
        drop_cmd();
        tick();
        check("iss_start", 32'(start), 32'd1);
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        check("iss_done_ign", 32'(cmd_done), 32'd0);
        check("iss_in_wait", 32'(idle), 32'd0);
        tick();
        check("iss_no_late_done", 32'(cmd_done), 32'd0);
        complete("iss");
        tick();

        // fill the queue; busy held high must not matter
        eng_busy = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            set_cmd(10 * k, k, k, k);
            rdy_seen[k] = cmd_ready;
            tick();
            if (k == 4) check("f_pend4", 32'(pending), 32'd3);
            if (k == 5) begin
                check("f_pend5", 32'(pending), 32'd4);
                check("f_rdy_full", 32'(cmd_ready), 32'd0);
            end
            if (k == 6) check("f_pend6", 32'(pending), 32'd4);
        end
        drop_cmd();
        check("f_rdy5_seen", 32'(rdy_seen[5]), 32'd1);
        check("f_rdy6_seen", 32'(rdy_seen[6]), 32'd0);
        check("f_x1", 32'(xC), 32'd10);
        complete("f1");
        for (int k = 2; k <= 5; k++) begin
            wait_start($sformatf("f%0d", k), 10 * k);
            complete($sformatf("f%0d", k));
        end
        extra = 0;
        repeat (8) begin
            tick();
            if (start) extra++;
        end
        check("f_no_sixth", 32'(extra), 32'd0);
        check("f_idle", 32'(idle), 32'd1);
        eng_busy = 1'b0;

        // steady state at pending=2: push and pop in the same edge, across pointer wrap
        for (int k = 0; k < 3; k++) begin
            set_cmd(100 + k, k, k, k);
            tick();
        end
        drop_cmd();
        check("w_pend", 32'(pending), 32'd2);
        check("w_x0", 32'(xC), 32'd100);
        for (int n = 0; n < 17; n++) begin
            eng_done = 1'b1;
            tick();
            eng_done = 1'b0;
            check("w_done", 32'(cmd_done), 32'd1);
            set_cmd(103 + n, n, n, n);
            tick();
            drop_cmd();
            check("w_pend_const", 32'(pending), 32'd2);
            check("w_start", 32'(start), 32'd1);
            check("w_x", 32'(xC), 32'(101 + n));
            tick();
        end
        complete("w17");
        wait_start("w18", 118);
        complete("w18");
        wait_start("w19", 119);
        complete("w19");
        tick();
        check("w_idle", 32'(idle), 32'd1);

        // abort in WAIT with pending=3
        for (int k = 0; k < 4; k++) begin
            set_cmd(200 + k, k, k, k);
            tick();
        end
        check("a_pend3", 32'(pending), 32'd3);
        set_cmd(250, 1, 1, 1);
        abort = 1'b1;
        #1;
        check("a_rdy_blocked", 32'(cmd_ready), 32'd0);
        tick();
        abort = 1'b0;
        drop_cmd();
        check("a_pend0", 32'(pending), 32'd0);
        check("a_still_wait", 32'(idle), 32'd0);
        check("a_x_kept", 32'(xC), 32'd200);
        complete("a");
        check("a_idle", 32'(idle), 32'd1);
        extra = 0;
        repeat (10) begin
            tick();
            if (start) extra++;
        end
        check("a_no_start", 32'(extra), 32'd0);

        // abort in IDLE blocks the pop
        set_cmd(300, 3, 3, 3);
        tick();
        drop_cmd();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ai_no_start", 32'(start), 32'd0);
        check("ai_pend", 32'(pending), 32'd0);
        check("ai_idle", 32'(idle), 32'd1);
        tick();
        check("ai_no_start2", 32'(start), 32'd0);

        // reset during WAIT discards the in-flight command
        set_cmd(400, 9, 9, 9);
        tick();
        set_cmd(401, 9, 9, 9);
        tick();
        drop_cmd();
        tick();
        check("r_in_wait", 32'(idle), 32'd0);
        check("r_pend_pre", 32'(pending), 32'd1);
        n_rst = 1'b0;
        tick();
        check("r_xC", 32'(xC), 32'd0);
        check("r_rgb", 32'({r_o, g_o, b_o}), 32'd0);
        check("r_pend", 32'(pending), 32'd0);
        check("r_start", 32'(start), 32'd0);
        check("r_idle", 32'(idle), 32'd1);
        n_rst = 1'b1;
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        check("r_no_done", 32'(cmd_done), 32'd0);
        check("r_rdy", 32'(cmd_ready), 32'd1);
        tick();
        check("r_no_done2", 32'(cmd_done), 32'd0);
        check("r_no_start", 32'(start), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
